// File: rtl/tile_rom_pkg.sv
// Shared types and default sizes for the tile ROM arbiter slice.
// Imported by the interface, the hit register and the top.
package tile_rom_pkg;

  localparam int AW_DEF           = 18;
  localparam int DW_DEF           = 32;
  localparam int VID_DEADLINE_DEF = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VID_WAIT = 2'd1,
    CPU_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/tile_rom_arbiter_if.sv
// Tile ROM memory port: level request/address out, one-cycle ack with data back.
// The arbiter is the master; the SDRAM controller side is the slave.
interface tile_rom_arbiter_if import tile_rom_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_dout;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_dout
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_dout
  );

endinterface

// File: rtl/tile_rom_hit_reg.sv
// One-entry video hit register: remembers the last fetched address/data pair
// and flags a hit when a new address matches it over the full width.
module tile_rom_hit_reg import tile_rom_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic [AW-1:0] cmp_addr,
  output logic          hit,
  output logic [DW-1:0] data
);

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      addr_d  = load_addr;
      data_d  = load_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign hit  = valid_q && (cmp_addr == addr_q);
  assign data = data_q;

endmodule

// File: rtl/tile_rom_arbiter.sv
// Shares the tile ROM port between deadline-bound video fetches and CPU readback.
// Video always wins; a one-entry hit register short-circuits repeated video fetches.
module tile_rom_arbiter import tile_rom_pkg::*; #(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int VID_DEADLINE = VID_DEADLINE_DEF
) (
  input  logic               clk_24M,
  input  logic               nRES,
  input  logic               vid_strobe,
  input  logic [AW-1:0]      vid_addr,
  output logic [DW-1:0]      vid_data,
  output logic               vid_valid,
  output logic               vid_late,
  output logic               vid_overrun,
  input  logic               cpu_req,
  input  logic [AW-1:0]      cpu_addr,
  output logic [DW-1:0]      cpu_data,
  output logic               cpu_ack,
  tile_rom_arbiter_if.master mem
);

  localparam int            DL_W    = $clog2(VID_DEADLINE + 1);
  localparam logic [DL_W-1:0] DL_MAX  = DL_W'(VID_DEADLINE);
  localparam logic [DL_W-1:0] DL_LAST = DL_W'(VID_DEADLINE - 1);

  state_e          state_q, state_d;
  logic            vpend_q, vpend_d;
  logic [AW-1:0]   vpend_addr_q, vpend_addr_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   cpu_data_q, cpu_data_d;
  logic            cpu_served_q, cpu_served_d;
  logic            vid_valid_q, vid_valid_d;
  logic            vid_overrun_q, vid_overrun_d;
  logic            vid_late_q, vid_late_d;
  logic [DL_W-1:0] dl_cnt_q, dl_cnt_d;
  logic            late_done_q, late_done_d;

  logic            hit;
  logic            hit_load;
  logic [DW-1:0]   hit_data;
  logic            vid_hit;
  logic            vid_miss;
  logic            vid_outstanding;

  tile_rom_hit_reg #(
    .AW (AW),
    .DW (DW)
  ) u_hit_reg (
    .clk       (clk_24M),
    .rst_n     (nRES),
    .load      (hit_load),
    .load_addr (mem_addr_q),
    .load_data (mem.mem_dout),
    .cmp_addr  (vid_addr),
    .hit       (hit),
    .data      (hit_data)
  );

  assign vid_hit         = vid_strobe && hit;
  assign vid_miss        = vid_strobe && !hit;
  assign vid_outstanding = vpend_q || (state_q == VID_WAIT);

  // A miss strobe seen in IDLE is granted directly so mem_req rises one cycle later.
  always_comb begin
    state_d       = state_q;
    vpend_d       = vpend_q;
    vpend_addr_d  = vpend_addr_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    cpu_data_d    = cpu_data_q;
    cpu_served_d  = cpu_served_q;
    vid_valid_d   = 1'b0;
    vid_overrun_d = 1'b0;
    hit_load      = 1'b0;

    if (vid_miss) begin
      vpend_d       = 1'b1;
      vpend_addr_d  = vid_addr;
      vid_overrun_d = vpend_q;
    end
    if (vid_hit) begin
      vid_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (vpend_d) begin
          state_d    = VID_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = vpend_addr_d;
          vpend_d    = 1'b0;
        end else if (cpu_req && !cpu_served_q) begin
          state_d    = CPU_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = cpu_addr;
        end
      end
      VID_WAIT: begin
        if (mem.mem_ack) begin
          vid_valid_d = 1'b1;
          hit_load    = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      CPU_WAIT: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (cpu_req) begin
            cpu_data_d   = mem.mem_dout;
            cpu_served_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (!cpu_req) begin
      cpu_served_d = 1'b0;
    end
  end

  // Deadline restarts on each miss strobe and fires at most once per fetch.
  always_comb begin
    dl_cnt_d    = dl_cnt_q;
    late_done_d = late_done_q;
    vid_late_d  = 1'b0;
    if (vid_miss) begin
      dl_cnt_d    = {{(DL_W-1){1'b0}}, 1'b1};
      late_done_d = 1'b0;
    end else if (vid_outstanding) begin
      if (dl_cnt_q != DL_MAX) begin
        dl_cnt_d = dl_cnt_q + 1'b1;
      end
      if (!late_done_q && (dl_cnt_q == DL_LAST)) begin
        vid_late_d  = 1'b1;
        late_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      state_q       <= IDLE;
      vpend_q       <= 1'b0;
      vpend_addr_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      cpu_data_q    <= '0;
      cpu_served_q  <= 1'b0;
      vid_valid_q   <= 1'b0;
      vid_overrun_q <= 1'b0;
      vid_late_q    <= 1'b0;
      dl_cnt_q      <= '0;
      late_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vpend_q       <= vpend_d;
      vpend_addr_q  <= vpend_addr_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      cpu_data_q    <= cpu_data_d;
      cpu_served_q  <= cpu_served_d;
      vid_valid_q   <= vid_valid_d;
      vid_overrun_q <= vid_overrun_d;
      vid_late_q    <= vid_late_d;
      dl_cnt_q      <= dl_cnt_d;
      late_done_q   <= late_done_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign vid_data     = hit_data;
  assign vid_valid    = vid_valid_q;
  assign vid_late     = vid_late_q;
  assign vid_overrun  = vid_overrun_q;
  assign cpu_data     = cpu_data_q;
  assign cpu_ack      = cpu_served_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Directed bench for tile_rom_arbiter: the memory side is driven by hand and
// every expected value is a hand-computed constant.
module tb_tile_rom_arbiter;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk_24M = 1'b0;
  logic          nRES    = 1'b0;
  logic          vid_strobe;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_late;
  logic          vid_overrun;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_ack;

  int n_compared   = 0;
  int n_mismatched = 0;
  int ovr_count;
  int late_count;
  int late_at;

  tile_rom_arbiter_if #(.AW(AW), .DW(DW)) mem_bus ();

  tile_rom_arbiter #(.AW(AW), .DW(DW), .VID_DEADLINE(12)) dut (
    .clk_24M     (clk_24M),
    .nRES        (nRES),
    .vid_strobe  (vid_strobe),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .vid_late    (vid_late),
    .vid_overrun (vid_overrun),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_ack     (cpu_ack),
    .mem         (mem_bus)
  );

  always #20 clk_24M = ~clk_24M;

  // Registered outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_24M);
    #1;
  endtask

  task automatic applyStimulus(input logic strobe, input logic [AW-1:0] vaddr,
                               input logic creq, input logic [AW-1:0] caddr);
    vid_strobe = strobe;
    vid_addr   = vaddr;
    cpu_req    = creq;
    cpu_addr   = caddr;
  endtask

  task automatic driveMem(input logic ack, input logic [DW-1:0] dout);
    mem_bus.mem_ack  = ack;
    mem_bus.mem_dout = dout;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with every input driven high: all outputs must read zero.
    applyStimulus(1'b1, '1, 1'b1, '1);
    driveMem(1'b1, '1);
    repeat (3) tick();
    checkOutput("rst_vid_data",    vid_data,         32'h0);
    checkOutput("rst_vid_valid",   vid_valid,        32'h0);
    checkOutput("rst_vid_late",    vid_late,         32'h0);
    checkOutput("rst_vid_overrun", vid_overrun,      32'h0);
    checkOutput("rst_cpu_data",    cpu_data,         32'h0);
    checkOutput("rst_cpu_ack",     cpu_ack,          32'h0);
    checkOutput("rst_mem_req",     mem_bus.mem_req,  32'h0);
    checkOutput("rst_mem_addr",    mem_bus.mem_addr, 32'h0);

    applyStimulus(1'b0, '0, 1'b0, '0);
    driveMem(1'b0, '0);
    #5 nRES = 1'b1;
    tick();
    tick();
    checkOutput("idle_mem_req", mem_bus.mem_req, 32'h0);

    // Video miss at 0x01234, ack three cycles after mem_req.
    applyStimulus(1'b1, 18'h01234, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("miss_mem_req",  mem_bus.mem_req,  32'h1);
    checkOutput("miss_mem_addr", mem_bus.mem_addr, 32'h01234);
    tick();
    tick();
    checkOutput("miss_no_valid_yet", vid_valid, 32'h0);
    tick();
    driveMem(1'b1, 32'hDEADBEEF);
    tick();
    driveMem(1'b0, '0);
    checkOutput("miss_vid_valid", vid_valid,       32'h1);
    checkOutput("miss_vid_data",  vid_data,        32'hDEADBEEF);
    checkOutput("miss_vid_late",  vid_late,        32'h0);
    checkOutput("miss_mem_drop",  mem_bus.mem_req, 32'h0);
    tick();
    checkOutput("miss_valid_pulse", vid_valid, 32'h0);

    // Repeat strobe to the same address is served from the hit register.
    applyStimulus(1'b1, 18'h01234, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("hit_vid_valid", vid_valid,       32'h1);
    checkOutput("hit_vid_data",  vid_data,        32'hDEADBEEF);
    checkOutput("hit_mem_req",   mem_bus.mem_req, 32'h0);
    tick();
    checkOutput("hit_mem_req_after", mem_bus.mem_req, 32'h0);

    // Simultaneous CPU request and video strobe: video first, then CPU.
    applyStimulus(1'b1, 18'h00010, 1'b1, 18'h3FFFF);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 18'h3FFFF);
    checkOutput("prio_vid_addr", mem_bus.mem_addr, 32'h00010);
    checkOutput("prio_vid_req",  mem_bus.mem_req,  32'h1);
    tick();
    driveMem(1'b1, 32'h11111111);
    tick();
    driveMem(1'b0, '0);
    checkOutput("prio_vid_valid", vid_valid,       32'h1);
    checkOutput("prio_vid_data",  vid_data,        32'h11111111);
    checkOutput("prio_gap",       mem_bus.mem_req, 32'h0);
    tick();
    checkOutput("prio_cpu_req",  mem_bus.mem_req,  32'h1);
    checkOutput("prio_cpu_addr", mem_bus.mem_addr, 32'h3FFFF);
    checkOutput("prio_no_ack",   cpu_ack,          32'h0);
    driveMem(1'b1, 32'hCAFEF00D);
    tick();
    driveMem(1'b0, '0);
    checkOutput("prio_cpu_ack",  cpu_ack,         32'h1);
    checkOutput("prio_cpu_data", cpu_data,        32'hCAFEF00D);
    checkOutput("prio_cpu_drop", mem_bus.mem_req, 32'h0);
    tick();
    checkOutput("prio_ack_hold", cpu_ack,         32'h1);
    checkOutput("prio_no_refetch", mem_bus.mem_req, 32'h0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    #1;
    checkOutput("prio_ack_still", cpu_ack, 32'h1);
    tick();
    checkOutput("prio_ack_clear", cpu_ack, 32'h0);

    // Long CPU fetch with two video strobes behind it: one overrun, one late pulse.
    applyStimulus(1'b0, '0, 1'b1, 18'h00500);
    tick();
    checkOutput("dl_cpu_addr", mem_bus.mem_addr, 32'h00500);
    applyStimulus(1'b1, 18'h00020, 1'b1, 18'h00500);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 18'h00500);
    checkOutput("dl_first_no_ovr", vid_overrun, 32'h0);
    tick();
    applyStimulus(1'b1, 18'h00030, 1'b1, 18'h00500);
    ovr_count  = 0;
    late_count = 0;
    late_at    = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      applyStimulus(1'b0, '0, 1'b1, 18'h00500);
      if (vid_overrun) ovr_count++;
      if (vid_late) begin
        late_count++;
        late_at = k;
      end
      if (k == 18) driveMem(1'b1, 32'hABCD1234);
    end
    tick();
    driveMem(1'b0, '0);
    checkOutput("dl_cpu_ack",   cpu_ack,         32'h1);
    checkOutput("dl_cpu_data",  cpu_data,        32'hABCD1234);
    checkOutput("dl_cpu_drop",  mem_bus.mem_req, 32'h0);
    tick();
    checkOutput("dl_vid_req",   mem_bus.mem_req,  32'h1);
    checkOutput("dl_vid_addr",  mem_bus.mem_addr, 32'h00030);
    checkOutput("dl_ovr_count", ovr_count,  32'd1);
    checkOutput("dl_late_count", late_count, 32'd1);
    checkOutput("dl_late_cycle", late_at,    32'd12);
    driveMem(1'b1, 32'h30303030);
    tick();
    driveMem(1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("dl_vid_valid", vid_valid, 32'h1);
    checkOutput("dl_vid_data",  vid_data,  32'h30303030);
    checkOutput("dl_no_relate", vid_late,  32'h0);
    tick();

    // Asynchronous reset during VID_WAIT drops mem_req at once; late ack ignored.
    applyStimulus(1'b1, 18'h00040, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("mid_req_before", mem_bus.mem_req, 32'h1);
    #5 nRES = 1'b0;
    #1;
    checkOutput("mid_req_dropped", mem_bus.mem_req, 32'h0);
    checkOutput("mid_vid_data",    vid_data,        32'h0);
    #5 nRES = 1'b1;
    tick();
    driveMem(1'b1, 32'h55555555);
    tick();
    driveMem(1'b0, '0);
    checkOutput("stray_no_valid", vid_valid,       32'h0);
    checkOutput("stray_no_req",   mem_bus.mem_req, 32'h0);
    tick();
    checkOutput("stray_no_valid2", vid_valid, 32'h0);

    // Hit register was invalidated by reset, so the old address misses again.
    applyStimulus(1'b1, 18'h01234, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("post_rst_miss_req",  mem_bus.mem_req,  32'h1);
    checkOutput("post_rst_miss_addr", mem_bus.mem_addr, 32'h01234);
    checkOutput("post_rst_no_hit",    vid_valid,        32'h0);
    driveMem(1'b1, 32'h99999999);
    tick();
    driveMem(1'b0, '0);
    checkOutput("post_rst_valid", vid_valid, 32'h1);
    checkOutput("post_rst_data",  vid_data,  32'h99999999);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
